mul_frame_ctrl: RTL

- Sequencer in front of the per-frame energy accumulator/compressor (mul_calc datapath).
- Accepts the FFT-bin energy stream over AXI-Stream and issues single-cycle e_ready strobes with safe spacing.
- Keeps the accumulator's bin count aligned to frame boundaries (pads short frames, drops long ones) and holds the next frame until the result handoff completes.
- Applies runtime threshold/ratio configuration only at frame boundaries.

---
 rtl/mul_frame_ctrl_pkg.sv | 19 +
 rtl/mul_frame_ctrl_if.sv | 12 +
 rtl/mul_frame_ctrl_cfg_shadow.sv | 64 ++++++
 rtl/mul_frame_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mul_frame_ctrl_pkg.sv
// rtl/mul_frame_ctrl_pkg.sv - shared types and constants for the energy frame sequencer
package mul_ctrl_pkg;

    typedef enum logic [2:0] {
        ACCEPT   = 3'd0,
        GAP      = 3'd1,
        PAD      = 3'd2,
        DROP     = 3'd3,
        WAIT_RES = 3'd4,
        APPLY    = 3'd5
    } state_e;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_TMO   = 2;
    localparam int ERR_CFG   = 3;
    localparam int ERR_W     = 4;

endpackage

// File: rtl/mul_frame_ctrl_if.sv
// rtl/mul_frame_ctrl_if.sv - AXI-Stream energy bin input bundle
interface mul_frame_ctrl_if #(
    parameter int DW = 40
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/mul_frame_ctrl_cfg_shadow.sv
// rtl/mul_frame_ctrl_cfg_shadow.sv - pending/active threshold and ratio registers
module mul_cfg_shadow #(
    parameter int THRESH_DEFAULT = 1000,
    parameter int RATIO_DEFAULT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr_i,
    input  logic [31:0] cfg_thresh_i,
    input  logic [15:0] cfg_ratio_i,
    input  logic        apply_i,
    output logic [31:0] act_thresh_o,
    output logic [15:0] act_ratio_o,
    output logic        cfg_rej_o
);

    logic [31:0] pend_thresh_q, pend_thresh_d;
    logic [15:0] pend_ratio_q,  pend_ratio_d;
    logic        pend_vld_q,    pend_vld_d;
    logic [31:0] act_thresh_q,  act_thresh_d;
    logic [15:0] act_ratio_q,   act_ratio_d;

    assign cfg_rej_o    = cfg_wr_i && (cfg_ratio_i == 16'd0);
    assign act_thresh_o = act_thresh_q;
    assign act_ratio_o  = act_ratio_q;

    // A write landing on the apply cycle is kept pending for the following frame.
    always_comb begin
        pend_thresh_d = pend_thresh_q;
        pend_ratio_d  = pend_ratio_q;
        pend_vld_d    = pend_vld_q;
        act_thresh_d  = act_thresh_q;
        act_ratio_d   = act_ratio_q;
        if (apply_i) begin
            if (pend_vld_q) begin
                act_thresh_d = pend_thresh_q;
                act_ratio_d  = pend_ratio_q;
            end
            pend_vld_d = 1'b0;
        end
        if (cfg_wr_i && !cfg_rej_o) begin
            pend_thresh_d = cfg_thresh_i;
            pend_ratio_d  = cfg_ratio_i;
            pend_vld_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_thresh_q <= '0;
            pend_ratio_q  <= '0;
            pend_vld_q    <= 1'b0;
            act_thresh_q  <= 32'(THRESH_DEFAULT);
            act_ratio_q   <= 16'(RATIO_DEFAULT);
        end else begin
            pend_thresh_q <= pend_thresh_d;
            pend_ratio_q  <= pend_ratio_d;
            pend_vld_q    <= pend_vld_d;
            act_thresh_q  <= act_thresh_d;
            act_ratio_q   <= act_ratio_d;
        end
    end

endmodule

// File: rtl/mul_frame_ctrl.sv
// rtl/mul_frame_ctrl.sv - frame-aligned strobe sequencer ahead of the energy accumulator
module mul_frame_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int ENRGY_DATA_WIDTH = 40,
    parameter int NUM_FFT_PTS      = 16,
    parameter int RES_TIMEOUT      = 64,
    parameter int THRESH_DEFAULT   = 1000,
    parameter int RATIO_DEFAULT    = 10
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    mul_frame_ctrl_if.slave             s_axis_e,
    output logic [ENRGY_DATA_WIDTH-1:0] energy,
    output logic                        e_ready,
    input  logic                        res_ack,
    input  logic [31:0]                 cfg_thresh,
    input  logic [15:0]                 cfg_ratio,
    input  logic                        cfg_wr,
    output logic [31:0]                 act_thresh,
    output logic [15:0]                 act_ratio,
    output logic                        busy,
    output logic [15:0]                 frame_cnt,
    output logic [ERR_W-1:0]            err_flags,
    input  logic                        err_clr
);

    localparam int BW = $clog2(NUM_FFT_PTS);
    localparam int TW = $clog2(RES_TIMEOUT);
    localparam logic [BW-1:0] BIN_LAST = BW'(NUM_FFT_PTS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RES_TIMEOUT - 1);

    state_e                      state_q, state_d;
    logic [BW-1:0]               bin_q, bin_d;
    logic [TW-1:0]               tmr_q, tmr_d;
    logic                        ph_q, ph_d;
    logic [ENRGY_DATA_WIDTH-1:0] energy_q, energy_d;
    logic                        e_ready_q, e_ready_d;
    logic                        tready_q, tready_d;
    logic [15:0]                 frame_q, frame_d;
    logic [ERR_W-1:0]            err_q, err_d, err_set;
    logic                        hs, apply, cfg_rej;

    assign hs              = s_axis_e.tvalid && tready_q;
    assign s_axis_e.tready = tready_q;
    assign energy          = energy_q;
    assign e_ready         = e_ready_q;
    assign frame_cnt       = frame_q;
    assign err_flags       = err_q;
    assign busy            = !((state_q == ACCEPT) && (bin_q == '0));

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        tmr_d     = '0;
        ph_d      = ph_q;
        energy_d  = energy_q;
        e_ready_d = 1'b0;
        frame_d   = frame_q;
        apply     = 1'b0;
        err_set   = '0;
        case (state_q)
            ACCEPT: if (hs) begin
                energy_d  = s_axis_e.tdata;
                e_ready_d = 1'b1;
                if (bin_q == BIN_LAST) begin
                    if (s_axis_e.tlast) begin
                        state_d = WAIT_RES;
                    end else begin
                        err_set[ERR_LONG] = 1'b1;
                        state_d           = DROP;
                    end
                end else if (s_axis_e.tlast) begin
                    err_set[ERR_SHORT] = 1'b1;
                    state_d            = PAD;
                    bin_d              = bin_q + BW'(1);
                    ph_d               = 1'b0;
                end else begin
                    state_d = GAP;
                    bin_d   = bin_q + BW'(1);
                end
            end
            GAP: state_d = ACCEPT;
            // ph_q alternates idle/strobe so padding keeps the same two-cycle spacing.
            PAD: begin
                if (ph_q) begin
                    e_ready_d = 1'b1;
                    energy_d  = '0;
                    ph_d      = 1'b0;
                    if (bin_q == BIN_LAST) state_d = WAIT_RES;
                    else                   bin_d   = bin_q + BW'(1);
                end else begin
                    ph_d = 1'b1;
                end
            end
            DROP: if (hs && s_axis_e.tlast) state_d = WAIT_RES;
            WAIT_RES: begin
                tmr_d = tmr_q + TW'(1);
                if (res_ack) begin
                    state_d = APPLY;
                end else if (tmr_q == TMO_LAST) begin
                    err_set[ERR_TMO] = 1'b1;
                    state_d          = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                frame_d = frame_q + 16'd1;
                bin_d   = '0;
                state_d = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase
        err_set[ERR_CFG] = cfg_rej;
        err_d            = (err_clr ? '0 : err_q) | err_set;
        tready_d         = (state_d == ACCEPT) || (state_d == DROP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ACCEPT;
            bin_q     <= '0;
            tmr_q     <= '0;
            ph_q      <= 1'b0;
            energy_q  <= '0;
            e_ready_q <= 1'b0;
            tready_q  <= 1'b0;
            frame_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            tmr_q     <= tmr_d;
            ph_q      <= ph_d;
            energy_q  <= energy_d;
            e_ready_q <= e_ready_d;
            tready_q  <= tready_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    mul_cfg_shadow #(
        .THRESH_DEFAULT (THRESH_DEFAULT),
        .RATIO_DEFAULT  (RATIO_DEFAULT)
    ) u_cfg (
        .clk          (aclk),
        .rst_n        (aresetn),
        .cfg_wr_i     (cfg_wr),
        .cfg_thresh_i (cfg_thresh),
        .cfg_ratio_i  (cfg_ratio),
        .apply_i      (apply),
        .act_thresh_o (act_thresh),
        .act_ratio_o  (act_ratio),
        .cfg_rej_o    (cfg_rej)
    );

endmodule
